// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------
// load_store_unit_if : request/response and byte-memory bus of the LSU
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [1:0]            ReqSize;
  logic                  ReqSigned;
  logic [31:0]           ReqAddress;
  logic [0:31]           ReqWriteData;
  logic                  RespValid;
  logic                  RespError;
  logic [31:0]           RespData;
  logic                  MemEn;
  logic                  MemWe;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [7:0]            MemWData;
  logic [7:0]            MemRData;

  // Datapath and memory side: issues requests, returns read bytes
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData, MemRData,
    input  ReqReady, RespValid, RespError, RespData, MemEn, MemWe, MemAddr, MemWData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData, MemRData,
    output ReqReady, RespValid, RespError, RespData, MemEn, MemWe, MemAddr, MemWData
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------
// load_store_unit : byte-serial big-endian load/store initiator
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_XFER    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            r_state;
  logic                  r_write;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [1:0]            r_last;
  logic [1:0]            r_k;
  logic [31:0]           r_wdata;
  logic [23:0]           r_acc;
  logic                  r_resp_valid;
  logic                  r_resp_error;
  logic [31:0]           r_resp_data;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;

  logic [1:0]            w_last;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [32:0]           w_end_addr;

  // Byte k of an N-byte value, most significant first
  function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] last,
                                           input logic [1:0] k);
    logic [1:0] idx;
    idx = last - k;
    case (idx)
      2'd0:    pick_byte = d[7:0];
      2'd1:    pick_byte = d[15:8];
      2'd2:    pick_byte = d[23:16];
      default: pick_byte = d[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'd1:    extend = {{24{sgn & v[7]}}, v[7:0]};
      2'd2:    extend = {{16{sgn & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    w_last         = (bus.ReqSize == 2'd1) ? 2'd0 : (bus.ReqSize == 2'd2) ? 2'd1 : 2'd3;
    w_misaligned   = ((bus.ReqSize == 2'd2) && bus.ReqAddress[0]) ||
                     ((bus.ReqSize == 2'd3) && (bus.ReqAddress[1:0] != 2'd0));
    // 33-bit sum so addresses near 2^32 cannot wrap past the range check
    w_end_addr     = {1'b0, bus.ReqAddress} + {31'd0, w_last};
    w_out_of_range = w_end_addr >= (33'd1 << ADDR_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'd0;
      r_last       <= 2'd0;
      r_k          <= 2'd0;
      r_wdata      <= 32'd0;
      r_acc        <= 24'd0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= 32'd0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            r_write  <= bus.ReqWrite;
            r_signed <= bus.ReqSigned;
            r_size   <= bus.ReqSize;
            r_last   <= w_last;
            r_wdata  <= bus.ReqWriteData;
            r_k      <= 2'd0;
            r_acc    <= 24'd0;
            if (bus.ReqSize == 2'd0 || w_misaligned || w_out_of_range) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_error <= (bus.ReqSize != 2'd0);
              r_resp_data  <= 32'd0;
            end else begin
              r_state     <= S_XFER;
              r_mem_en    <= 1'b1;
              r_mem_we    <= bus.ReqWrite;
              r_mem_addr  <= bus.ReqAddress[ADDR_WIDTH-1:0];
              r_mem_wdata <= pick_byte(bus.ReqWriteData, w_last, 2'd0);
            end
          end
        end
        S_XFER: begin
          // Read data trails the issue by one cycle, so byte k-1 arrives now
          if (r_k != 2'd0) r_acc <= {r_acc[15:0], bus.MemRData};
          if (r_k == r_last) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            if (r_write) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_data  <= 32'd0;
            end else begin
              r_state <= S_CAPTURE;
            end
          end else begin
            r_k         <= r_k + 2'd1;
            r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
            r_mem_wdata <= pick_byte(r_wdata, r_last, r_k + 2'd1);
          end
        end
        S_CAPTURE: begin
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
          r_resp_error <= 1'b0;
          r_resp_data  <= extend({r_acc, bus.MemRData}, r_size, r_signed);
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_resp_data  <= 32'd0;
        end
      endcase
    end
  end

  assign bus.ReqReady  = (r_state == S_IDLE);
  assign bus.RespValid = r_resp_valid;
  assign bus.RespError = r_resp_error;
  assign bus.RespData  = r_resp_data;
  assign bus.MemEn     = r_mem_en;
  assign bus.MemWe     = r_mem_we;
  assign bus.MemAddr   = r_mem_addr;
  assign bus.MemWData  = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------
// tb_load_store_unit : directed + random requests against a byte-array model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(8)) bus ();

  load_store_unit #(.ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.MemEn) begin
      if (bus.MemWe) mem[bus.MemAddr] <= bus.MemWData;
      bus.MemRData <= mem[bus.MemAddr];
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
  } access_t;
  access_t acc_q[$];

  always @(negedge clk) begin
    if (bus.MemEn) acc_q.push_back('{addr: bus.MemAddr, we: bus.MemWe, data: bus.MemWData});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.ReqValid     = 1'b1;
    bus.ReqWrite     = w;
    bus.ReqSize      = sz;
    bus.ReqSigned    = sg;
    bus.ReqAddress   = a;
    bus.ReqWriteData = wd;
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!bus.ReqReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_timeout", 32'(bus.ReqReady), 32'd1);
  endtask

  // Called just after the acceptance edge; follows the request to its response
  task automatic finish_req(input bit w, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd);
    int n, lat, exp_lat, idx;
    bit err, got, ready_seen;
    longint unsigned aa;
    longint v;
    logic [31:0] exp_data;
    n  = (sz == 2'd0) ? 0 : (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    aa = a;
    err = (n > 1 && (aa % n) != 0) || (n > 0 && aa + n - 1 >= 256);
    exp_lat  = (n == 0 || err) ? 1 : (w ? n + 1 : n + 2);
    exp_data = 32'd0;
    if (!w && !err && n > 0) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + ref_mem[int'(aa) + i];
      if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      exp_data = v[31:0];
    end
    lat = 0; got = 1'b0; ready_seen = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.RespValid) got = 1'b1;
      else if (bus.ReqReady) ready_seen = 1'b1;
    end
    check_eq("resp_timeout", 32'(got), 32'd1);
    check_eq("resp_latency", 32'(lat), 32'(exp_lat));
    check_eq("ready_busy", 32'(ready_seen), 32'd0);
    check_eq("resp_error", 32'(bus.RespError), 32'(err));
    check_eq("resp_data", bus.RespData, exp_data);
    check_eq("mem_accesses", 32'(acc_q.size()), err ? 32'd0 : 32'(n));
    if (!err) begin
      for (int i = 0; i < n && i < acc_q.size(); i++) begin
        idx = int'(aa) + i;
        check_eq("mem_addr", 32'(acc_q[i].addr), 32'(idx));
        check_eq("mem_we", 32'(acc_q[i].we), 32'(w));
        if (w) begin
          check_eq("mem_wdata", 32'(acc_q[i].data), (wd >> (8 * (n - 1 - i))) & 32'hFF);
          ref_mem[idx] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        end
      end
    end
  endtask

  task automatic run_req(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    drive_req(w, sz, sg, a, wd);
    wait_ready();
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    acc_q.delete();
    finish_req(w, sz, sg, a, wd);
    @(negedge clk);
    check_eq("resp_pulse", 32'(bus.RespValid), 32'd0);
    check_eq("ready_after", 32'(bus.ReqReady), 32'd1);
  endtask

  initial begin
    int mism;
    bit w, sg;
    logic [1:0] sz;
    logic [31:0] a;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0; bus.ReqSigned = 1'b0;
    bus.ReqAddress = 32'd0; bus.ReqWriteData = 32'd0;

    // Preload both memories with the same random image while reset is held
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_addr = 8'(i);
      pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    check_eq("rst_ready", 32'(bus.ReqReady), 32'd1);
    check_eq("rst_resp_valid", 32'(bus.RespValid), 32'd0);
    check_eq("rst_resp_data", bus.RespData, 32'd0);
    check_eq("rst_mem_en", 32'(bus.MemEn), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.MemAddr), 32'd0);
    check_eq("rst_mem_wdata", 32'(bus.MemWData), 32'd0);
    reset = 1'b0;

    run_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h11223344);
    run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    check_eq("tp_word_image", {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]}, 32'h11223344);
    run_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h80);
    run_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h7F);
    run_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    run_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    run_req(1'b0, 2'd2, 1'b1, 32'h20, 32'h0);
    run_req(1'b1, 2'd2, 1'b0, 32'h21, 32'hBEEF);
    run_req(1'b0, 2'd3, 1'b0, 32'hFE, 32'h0);
    run_req(1'b0, 2'd1, 1'b0, 32'h100, 32'h0);
    run_req(1'b1, 2'd0, 1'b0, 32'h40, 32'h12345678);

    // Store aborted by reset after its second byte
    @(negedge clk);
    drive_req(1'b1, 2'd3, 1'b0, 32'h30, 32'hAABBCCDD);
    wait_ready();
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_mem_en", 32'(bus.MemEn), 32'd0);
    check_eq("abort_ready", 32'(bus.ReqReady), 32'd1);
    mism = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.RespValid) mism++;
      @(negedge clk);
    end
    check_eq("abort_no_resp", 32'(mism), 32'd0);
    check_eq("abort_accesses", 32'(acc_q.size()), 32'd2);
    ref_mem[8'h30] = 8'hAA;
    ref_mem[8'h31] = 8'hBB;

    // Back-to-back: ReqValid held, load fields presented right after the store is taken
    @(negedge clk);
    drive_req(1'b1, 2'd1, 1'b0, 32'h50, 32'h5A);
    wait_ready();
    @(posedge clk);
    #1;
    drive_req(1'b0, 2'd1, 1'b0, 32'h50, 32'h0);
    acc_q.delete();
    finish_req(1'b1, 2'd1, 1'b0, 32'h50, 32'h5A);
    @(negedge clk);
    check_eq("b2b_ready", 32'(bus.ReqReady), 32'd1);
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    acc_q.delete();
    finish_req(1'b0, 2'd1, 1'b0, 32'h50, 32'h0);
    check_eq("b2b_load_byte", bus.RespData, 32'h5A);

    for (int t = 0; t < 150; t++) begin
      w  = 1'($urandom);
      sz = 2'($urandom);
      sg = 1'($urandom);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[0] = 1'b0;
        if (sz == 2'd3) a[1:0] = 2'd0;
      end
      if ($urandom_range(0, 15) == 0) a = $urandom;
      run_req(w, sz, sg, a, $urandom);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_eq("mem_image", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
